multiplicador_shift_add: RTL and testbench

//   Sequential unsigned shift-and-add multiplier: product pp = MD * MR.

---
 rtl/multiplicador_shift_add_pkg.sv | 14 +
 rtl/multiplicador_datapath.sv | 59 +++++
 rtl/multiplicador_shift_add.sv | 102 ++++++++++
 tb/tb_multiplicador_shift_add.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/multiplicador_shift_add_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding
// and the default operand width.
package multiplicador_shift_add_pkg;

   localparam int W_DEFAULT = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ADD   = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/multiplicador_datapath.sv
// Datapath of the shift-and-add multiplier: shifted multiplicand, shifted
// multiplier, product accumulator and bit counter, steered by FSM strobes.
module multiplicador_datapath
   import multiplicador_shift_add_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             add,
   input  logic             shift,
   input  logic [W-1:0]     MD,
   input  logic [W-1:0]     MR,
   output logic [2*W-1:0]   pp,
   output logic             last,
   output logic             zero
);

   localparam int CW = $clog2(W);

   logic [2*W-1:0] a_r;
   logic [W-1:0]   b_r;
   logic [CW-1:0]  cnt_r;
   logic [2*W-1:0] pp_r;

   // operand capture, conditional accumulate and per-bit shift
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_r   <= {(2*W){1'b0}};
         b_r   <= {W{1'b0}};
         cnt_r <= {CW{1'b0}};
         pp_r  <= {(2*W){1'b0}};
      end else if (load) begin
         a_r   <= {{W{1'b0}}, MD};
         b_r   <= MR;
         cnt_r <= {CW{1'b0}};
         pp_r  <= {(2*W){1'b0}};
      end else if (add) begin
         if (b_r[0]) begin
            pp_r <= pp_r + a_r;
         end else begin
            pp_r <= pp_r;
         end
      end else if (shift) begin
         a_r   <= a_r << 1;
         b_r   <= b_r >> 1;
         cnt_r <= cnt_r + CW'(1);
      end else begin
         pp_r  <= pp_r;
      end
   end

   // zero looks at the multiplier bits that remain after this shift
   assign last = (cnt_r == CW'(W - 1));
   assign zero = ((b_r >> 1) == {W{1'b0}});
   assign pp   = pp_r;

endmodule

// File: rtl/multiplicador_shift_add.sv
// Sequential unsigned shift-and-add multiplier, pp = MD * MR, one multiplier
// bit per two clocks. Define MULT_EARLY_EXIT_EN to finish once MR runs out of set bits.
module multiplicador_shift_add
   import multiplicador_shift_add_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic [W-1:0]     MD,
   input  logic [W-1:0]     MR,
   output logic [2*W-1:0]   pp,
   output logic             done
);

`ifdef MULT_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   state_t state_r;
   state_t next_s;
   logic   done_r;
   logic   load_s;
   logic   add_s;
   logic   shift_s;
   logic   last_s;
   logic   zero_s;
   logic   exit_s;

   multiplicador_datapath #(.W(W)) u_datapath (
      .clk   (clk),
      .rst   (rst),
      .load  (load_s),
      .add   (add_s),
      .shift (shift_s),
      .MD    (MD),
      .MR    (MR),
      .pp    (pp),
      .last  (last_s),
      .zero  (zero_s)
   );

   assign exit_s = last_s | (EARLY_EXIT & zero_s);

   // state register; done is registered from the next state so it tracks DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         done_r  <= 1'b0;
      end else begin
         state_r <= next_s;
         done_r  <= (next_s == DONE);
      end
   end

   // next-state decode and datapath strobes
   always_comb begin
      next_s  = state_r;
      load_s  = 1'b0;
      add_s   = 1'b0;
      shift_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (init) begin
               load_s = 1'b1;
               next_s = ADD;
            end else begin
               next_s = IDLE;
            end
         end
         ADD: begin
            add_s  = 1'b1;
            next_s = SHIFT;
         end
         SHIFT: begin
            shift_s = 1'b1;
            if (exit_s) begin
               next_s = DONE;
            end else begin
               next_s = ADD;
            end
         end
         DONE: begin
            // a held init must drop before another run can start
            if (init) begin
               next_s = DONE;
            end else begin
               next_s = IDLE;
            end
         end
         default: begin
            next_s = IDLE;
         end
      endcase
   end

   assign done = done_r;

endmodule

// File: tb/tb_multiplicador_shift_add.sv
// Randomized and directed self-checking bench for multiplicador_shift_add,
// compared against a plain-arithmetic product/latency model.
module tb_multiplicador_shift_add;

   localparam int W = 3;

   logic           clk;
   logic           rst;
   logic           init;
   logic [W-1:0]   MD;
   logic [W-1:0]   MR;
   logic [2*W-1:0] pp;
   logic           done;

   int vectors;
   int miscompares;

   multiplicador_shift_add #(.W(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .init (init),
      .MD   (MD),
      .MR   (MR),
      .pp   (pp),
      .done (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      vectors++;
      if (obs !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   // reference latency in edges from the sampling edge to done
   function automatic int ref_latency(input logic [W-1:0] mr);
      int top;
      int bits;
      top = -1;
      for (int i = 0; i < W; i++) begin
         if (mr[i]) top = i;
      end
      bits = (top + 1 < 1) ? 1 : top + 1;
`ifdef MULT_EARLY_EXIT_EN
      return 1 + 2 * bits;
`else
      return 2 * W + 1 + 0 * bits;
`endif
   endfunction

   task automatic run_op(input logic [W-1:0] md, input logic [W-1:0] mr, input bit scramble);
      int n;
      int expp;
      expp = int'(md) * int'(mr);
      @(negedge clk);
      MD   = md;
      MR   = mr;
      init = 1'b1;
      @(posedge clk);
      #1;
      n = 1;
      if (scramble) begin
         MD = W'($urandom);
         MR = W'($urandom);
      end
      while (!done && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("latency", n, ref_latency(mr));
      chk("product", {26'd0, pp}, expp);
      repeat (2) @(posedge clk);
      #1;
      chk("done_hold", {31'd0, done}, 32'd1);
      chk("pp_hold", {26'd0, pp}, expp);
      @(negedge clk);
      init = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_pp", {26'd0, pp}, expp);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst  = 1'b1;
      init = 1'b0;
      MD   = '0;
      MR   = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_pp", {26'd0, pp}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      run_op(3'd4, 3'd3, 1'b0);
      run_op(3'd7, 3'd7, 1'b0);
      run_op(3'd5, 3'd0, 1'b0);
      run_op(3'd2, 3'd6, 1'b0);
      run_op(3'd3, 3'd5, 1'b1);
      run_op(3'd6, 3'd7, 1'b1);

      // abort during the shift of bit 1
      @(negedge clk);
      MD   = 3'd7;
      MR   = 3'd7;
      init = 1'b1;
      repeat (4) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("abort_pp", {26'd0, pp}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      init = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run_op(3'd7, 3'd6, 1'b0);

      for (int a = 0; a < 8; a++) begin
         for (int b = 0; b < 8; b++) begin
            run_op(W'(a), W'(b), 1'b0);
         end
      end

      for (int k = 0; k < 20; k++) begin
         run_op(W'($urandom), W'($urandom), 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
